// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, register indices and FSM states for the SPI register bank
package spi_pkg;

   localparam int CMD_RW_BIT = 7;
   localparam int ADDR_W     = 7;
   localparam int BYTE_W     = 8;

   localparam int REG_BACKGROUND  = 0;
   localparam int REG_SOLID_COLOR = 1;
   localparam int REG_AUDIO_EN    = 2;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } spi_state_e;

endpackage

// File: rtl/spi_reg_bank_if.sv
// rtl/spi_reg_bank_if.sv - SPI pin bundle between host (master) and register bank (slave)
// sclk : SPI clock, mode 0
// ssel : select, active-low
// mosi : host-to-bank data, MSB first
// miso : bank-to-host data, MSB first
interface spi_reg_bank_if;

   logic sclk;
   logic ssel;
   logic mosi;
   logic miso;

   modport master (output sclk, output ssel, output mosi, input miso);
   modport slave  (input sclk, input ssel, input mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered rise/fall detection
// clk, rst : system clock, synchronous active-high reset
// din      : asynchronous input
// q        : synchronised level, time-aligned with rise/fall
// rise     : one-clk pulse after a 0->1 transition
// fall     : one-clk pulse after a 1->0 transition
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {STAGES{RST_VAL}};
         prev_r <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
         rise   <= sync_r[STAGES-1] & ~prev_r;
         fall   <= ~sync_r[STAGES-1] & prev_r;
      end
   end

   // prev_r holds the sample the edge pulses were derived from, so q and
   // rise/fall describe the same instant.
   assign q = prev_r;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 slave exposing NUM_REGS byte registers with readback and burst access
// clk, rst : system clock, synchronous active-high reset
// spi      : SPI pins (slave modport)
// regs_q   : flattened register contents, register i at [8i+7:8i]
// wr_stb   : one-clk pulse per committed write
// wr_addr  : address of the committed write
// wr_data  : data of the committed write
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int                      NUM_REGS    = 4,
   parameter logic [NUM_REGS*8-1:0]   RESET_VAL   = 32'h0000_000A,
   parameter int                      SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   spi_reg_bank_if.slave             spi,
   output logic [NUM_REGS*8-1:0]     regs_q,
   output logic                      wr_stb,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [BYTE_W-1:0]         wr_data
);

   spi_state_e        state, state_nxt;
   logic              sclk_rise, sclk_fall, ssel_rise, ssel_fall, mosi_s;
   logic              sclk_q_unused, ssel_q_unused, mosi_rise_unused, mosi_fall_unused;
   logic [2:0]        bit_cnt;
   logic [7:0]        rx_sr, tx_sr, shift_byte, rd_byte;
   logic [6:0]        ptr, ptr_inc, rd_addr;
   logic              is_rd, miso_r, ptr_ok, byte_done;
   logic [7:0]        regs [NUM_REGS];

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .din(spi.sclk),
      .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
      .clk(clk), .rst(rst), .din(spi.ssel),
      .q(ssel_q_unused), .rise(ssel_rise), .fall(ssel_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .din(spi.mosi),
      .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   // Byte as it stands once the current mosi bit is shifted in.
   assign shift_byte = {rx_sr[6:0], mosi_s};
   // ssel rising in the same sample as the 8th sclk rise aborts the byte.
   assign byte_done  = sclk_rise && (bit_cnt == 3'd7) && !ssel_rise;
   assign ptr_ok     = ({1'b0, ptr} < 8'(NUM_REGS));
   // Out-of-range pointers saturate instead of wrapping.
   assign ptr_inc    = !ptr_ok ? ptr :
                       (ptr == 7'(NUM_REGS - 1)) ? 7'd0 : ptr + 7'd1;
   // Address of the next byte to transmit: from the command in CMD,
   // otherwise the post-increment pointer.
   assign rd_addr    = (state == CMD) ? shift_byte[ADDR_W-1:0] : ptr_inc;

   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == 7'(i)) rd_byte = regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ssel_rise) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (ssel_fall) state_nxt = CMD;
            CMD:     if (byte_done) state_nxt = DATA;
            DATA:    state_nxt = DATA;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[8*i +: 8];
         bit_cnt <= 3'd0;
         rx_sr   <= 8'h00;
         tx_sr   <= 8'h00;
         ptr     <= 7'd0;
         is_rd   <= 1'b0;
         miso_r  <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_stb <= 1'b0;
         if (ssel_rise) begin
            bit_cnt <= 3'd0;
            is_rd   <= 1'b0;
            miso_r  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ssel_fall) begin
                     bit_cnt <= 3'd0;
                     rx_sr   <= 8'h00;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     rx_sr   <= shift_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ptr   <= shift_byte[ADDR_W-1:0];
                        is_rd <= shift_byte[CMD_RW_BIT];
                        if (shift_byte[CMD_RW_BIT]) begin
                           tx_sr  <= rd_byte;
                           miso_r <= rd_byte[7];
                        end
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx_sr   <= shift_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (!is_rd && ptr_ok) begin
                           for (int i = 0; i < NUM_REGS; i++) begin
                              if (ptr == 7'(i)) regs[i] <= shift_byte;
                           end
                           wr_stb  <= 1'b1;
                           wr_addr <= ptr;
                           wr_data <= shift_byte;
                        end
                        ptr <= ptr_inc;
                        if (is_rd) begin
                           tx_sr  <= rd_byte;
                           miso_r <= rd_byte[7];
                        end
                     end
                  end else if (sclk_fall && is_rd && (bit_cnt != 3'd0)) begin
                     // The fall right after a byte boundary keeps the freshly
                     // loaded MSB on the line for the host's next rise.
                     tx_sr  <= {tx_sr[6:0], 1'b0};
                     miso_r <= tx_sr[6];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
      assign regs_q[8*g +: 8] = regs[g];
   end

   assign spi.miso = miso_r;

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI slave register bank that replaces the fixed three-field SPI control decoder.
- It oversamples SCLK, SSEL and MOSI in the system clock domain and decodes framed transactions: one command byte, then N data bytes.
- It exposes NUM_REGS byte registers (background state, solid colour, audio enable, and later fields) to the rendering and audio logic.
- It adds readback over MISO, auto-incrementing burst access and a per-write strobe.

Parameters:
- NUM_REGS, 4, number of 8-bit registers; legal range 1..128.
- RESET_VAL, {8'h00,8'h00,8'h00,8'h0A}, flattened NUM_REGS*8 reset image; register i occupies bits [8i+7:8i].
- SYNC_STAGES, 2, synchroniser depth on SCLK/SSEL/MOSI; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- ssel  in  1  SPI select, active-low; high means idle.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first; registered.
- regs_q  out  NUM_REGS*8  flattened register contents.
- wr_stb  out  1  one-clk pulse per committed write.
- wr_addr  out  7  address of the committed write; valid with wr_stb.
- wr_data  out  8  data of the committed write; valid with wr_stb.

Behaviour:
- Reset (rst=1 at a clk edge):
  - regs_q = RESET_VAL.
  - miso=0, wr_stb=0, wr_addr=0, wr_data=0.
  - FSM goes to IDLE; bit counter, shift registers and address are cleared.
  - Synchroniser flops reset to sclk=0, ssel=1, mosi=0.
  - Reset mid-frame aborts the frame; the host must deassert ssel before the next frame.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - sclk rise/fall and ssel fall/rise are detected by comparing the last synchronised sample with the previous one.
  - All actions below happen on the clk edge after detection.
- FSM states:
  - IDLE: ssel high. On ssel fall: clear the bit counter, go to CMD.
  - CMD: shift mosi in on each sclk rise.
    - On the 8th rise the byte is cmd = {rw, addr[6:0]}, with rw=1 meaning read.
    - Latch addr into the pointer, then go to DATA.
    - If rw=1, load the tx shift register with the read value of addr and drive its MSB on miso in the same clk.
  - DATA: on each sclk rise shift mosi into rx; on each sclk fall shift tx left and drive the next bit on miso.
    - On the 8th rise of a byte, a write commits rx to regs_q[ptr] when ptr<NUM_REGS, and wr_stb/wr_addr/wr_data pulse for exactly one clk.
    - If ptr>=NUM_REGS, the write is dropped and wr_stb stays low.
    - After any full byte, read or write, ptr increments and the next tx byte is loaded; its MSB is driven on miso immediately.
  - Any state: on ssel rise, go to IDLE. A partial byte is discarded with no commit and no strobe.
- Read value: regs_q[ptr] when ptr<NUM_REGS, else 8'h00.
- Pointer wrap: ptr increments modulo NUM_REGS while ptr<NUM_REGS. An out-of-range ptr saturates and is never incremented.
- miso:
  - Forced to 0 in IDLE and in CMD.
  - Forced to 0 in DATA for write frames.
- Write latency: regs_q updates 1 clk after the synchronised 8th sclk rise, i.e. SYNC_STAGES+2 clk after the pin edge.
- A write and a read of the same register never collide, because each frame is read-only or write-only.
- Simultaneous ssel rise and sclk rise in the same sample: ssel wins, and the byte is not committed.

Decomposition:
- Shared package spi_pkg:
  - CMD_RW_BIT=7, ADDR_W=7, BYTE_W=8.
  - Register index constants: REG_BACKGROUND=0, REG_SOLID_COLOR=1, REG_AUDIO_EN=2.
  - FSM state enum {IDLE, CMD, DATA}.
- One natural sub-module: spi_sync_edge, which holds the SYNC_STAGES synchroniser plus rise/fall detectors. It is instantiated for sclk and ssel; a sync-only instance is used for mosi.

Test Plan:
- Reset: rst high 2 clk -> regs_q=0x00_00_00_0A, miso=0, wr_stb=0.
- Single write: frame 0x01,0x2A -> regs_q[15:8]=0x2A; one wr_stb with wr_addr=1, wr_data=0x2A; other registers unchanged.
- Burst write with wrap (NUM_REGS=4): frame 0x03,0x11,0x22 -> reg3=0x11, reg0=0x22; two wr_stb pulses, addresses 3 then 0.
- Burst read: preload reg0=0x0A, reg1=0x2A; frame 0x80 then 16 clocks -> miso bytes 0x0A,0x2A, MSB first, sampled on sclk rise.
- Out-of-range access: write frame 0x10,0xFF -> no wr_stb, regs_q unchanged. Read frame 0x90 -> miso 0x00.
- Aborts:
  - ssel rises after 5 data bits of 0x02,0x01 frame -> reg2 unchanged, no strobe.
  - rst asserted mid-burst -> regs_q=RESET_VAL, FSM IDLE.
